// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle RV32I control sequencer (fetch/decode/exec/mem/wb).
// Optional build macro MEM_TIMEOUT_EN adds a memory wait-state timeout with bus_err.
module mc_ctrl_fsm #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int INSTRET_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_write_br,
    output logic                 ir_write,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 alu_src,
    output logic [1:0]           alu_op,
    output logic                 reg_write,
    output logic                 illegal_op,
    output logic                 bus_err,
    output logic [2:0]           state_o,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;

    localparam logic [2:0] C_NONE  = 3'd0;
    localparam logic [2:0] C_R     = 3'd1;
    localparam logic [2:0] C_LOAD  = 3'd2;
    localparam logic [2:0] C_STORE = 3'd3;
    localparam logic [2:0] C_BR    = 3'd4;

    logic [2:0] state;
    logic [2:0] state_nx;
    logic [2:0] cls;
    logic [2:0] cls_nx;
    logic [2:0] dec_cls;
    logic       retire;
    logic       tmo;

    // Opcode class decode, only consumed in DECODE
    always_comb begin
        dec_cls = C_NONE;
        case (opcode)
            5'b01100: dec_cls = C_R;
            5'b00000: dec_cls = C_LOAD;
            5'b01000: dec_cls = C_STORE;
            5'b11000: dec_cls = C_BR;
            default:  dec_cls = C_NONE;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;

    assign waiting = (state == S_FETCH || state == S_MEM) && !mem_ready;
    assign tmo     = waiting && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Wait-cycle counter, cleared on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state_nx != state) begin
            wait_cnt <= '0;
        end else if (waiting) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT_CYCLES;
    assign tmo            = 1'b0;
`endif

    assign bus_err = tmo;

    // Next-state, class latch and retire decision
    always_comb begin
        state_nx = state;
        cls_nx   = cls;
        retire   = 1'b0;
        case (state)
            S_IDLE: state_nx = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_nx = S_DECODE;
                end else if (tmo) begin
                    state_nx = S_IDLE;
                end
            end
            S_DECODE: begin
                cls_nx   = dec_cls;
                state_nx = (dec_cls == C_NONE) ? S_FETCH : S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    C_R:     state_nx = S_WB;
                    C_LOAD:  state_nx = S_MEM;
                    C_STORE: state_nx = S_MEM;
                    C_BR: begin
                        state_nx = S_FETCH;
                        retire   = 1'b1;
                    end
                    default: state_nx = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (cls == C_LOAD) begin
                        state_nx = S_WB;
                    end else begin
                        state_nx = S_FETCH;
                        retire   = (cls == C_STORE);
                    end
                end else if (tmo) begin
                    state_nx = S_IDLE;
                end
            end
            S_WB: begin
                state_nx = S_FETCH;
                retire   = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, latched class and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cls     <= C_NONE;
            instret <= '0;
        end else begin
            state <= state_nx;
            cls   <= cls_nx;
            if (retire) begin
                instret <= instret + INSTRET_W'(1);
            end
        end
    end

    // Moore datapath controls, with mem_ready/zero qualifiers
    always_comb begin
        pc_write    = 1'b0;
        pc_write_br = 1'b0;
        ir_write    = 1'b0;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src     = 1'b0;
        alu_op      = 2'b00;
        reg_write   = 1'b0;
        illegal_op  = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read = 1'b1;
                pc_write = mem_ready;
                ir_write = mem_ready;
            end
            S_DECODE: illegal_op = (dec_cls == C_NONE);
            S_EXEC: begin
                case (cls)
                    C_R:     alu_op = 2'b10;
                    C_LOAD:  alu_src = 1'b1;
                    C_STORE: alu_src = 1'b1;
                    C_BR: begin
                        alu_op      = 2'b01;
                        pc_write_br = zero;
                    end
                    default: alu_op = 2'b00;
                endcase
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (cls == C_LOAD);
                mem_write = (cls == C_STORE);
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls == C_LOAD);
            end
            default: pc_write = 1'b0;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed self-checking bench for mc_ctrl_fsm.
// Build with MEM_TIMEOUT_EN defined to exercise the timeout path.
module tb_mc_ctrl_fsm;

    logic        clk;
    logic        rst_n;
    logic [4:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write;
    logic        pc_write_br;
    logic        ir_write;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic        reg_write;
    logic        illegal_op;
    logic        bus_err;
    logic [2:0]  state_o;
    logic [31:0] instret;

    int errors;
    int checks;
    int excl_viol;

    mc_ctrl_fsm #(
        .TIMEOUT_CYCLES(16),
        .INSTRET_W(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .opcode(opcode),
        .zero(zero),
        .mem_ready(mem_ready),
        .pc_write(pc_write),
        .pc_write_br(pc_write_br),
        .ir_write(ir_write),
        .i_or_d(i_or_d),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_to_reg(mem_to_reg),
        .alu_src(alu_src),
        .alu_op(alu_op),
        .reg_write(reg_write),
        .illegal_op(illegal_op),
        .bus_err(bus_err),
        .state_o(state_o),
        .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running watch for exclusivity rules, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_read && mem_write) excl_viol = excl_viol + 1;
        if (reg_write && state_o != 3'd5) excl_viol = excl_viol + 1;
    end

    function automatic logic [14:0] all_outs();
        return {pc_write, pc_write_br, ir_write, i_or_d, mem_read,
                mem_write, mem_to_reg, alu_src, alu_op, reg_write,
                illegal_op, bus_err, state_o == 3'd0 ? 1'b0 : 1'b1};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        opcode    = 5'b01100;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (all_outs() !== 15'd0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL reset_outs: got outs=%h instret=%0d want 0/0",
                     all_outs(), instret);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (state_o !== 3'd0 || all_outs() !== 15'd0) begin
            errors++;
            $display("FAIL idle_outs: got state=%0d outs=%h want 0/0",
                     state_o, all_outs());
        end
    endtask

    task automatic test_rtype();
        logic [2:0] seq [5];
        logic [2:0] want [5];
        want = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
        opcode    = 5'b01100;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            seq[i] = state_o;
            if (i == 0) begin
                checks++;
                if ({mem_read, i_or_d, pc_write, ir_write} !== 4'b1011) begin
                    errors++;
                    $display("FAIL fetch_ctl: got %b want 1011",
                             {mem_read, i_or_d, pc_write, ir_write});
                end
            end
            if (i == 2) begin
                checks++;
                if (alu_op !== 2'b10 || alu_src !== 1'b0 || reg_write !== 1'b0) begin
                    errors++;
                    $display("FAIL r_exec: got alu_op=%b src=%b rw=%b want 10/0/0",
                             alu_op, alu_src, reg_write);
                end
            end
            if (i == 3) begin
                checks++;
                if (reg_write !== 1'b1 || mem_to_reg !== 1'b0 || instret !== 32'd0) begin
                    errors++;
                    $display("FAIL r_wb: got rw=%b m2r=%b instret=%0d want 1/0/0",
                             reg_write, mem_to_reg, instret);
                end
            end
        end
        checks++;
        if (seq !== want) begin
            errors++;
            $display("FAIL r_seq: got %0d %0d %0d %0d %0d want 1 2 3 5 1",
                     seq[0], seq[1], seq[2], seq[3], seq[4]);
        end
        checks++;
        if (instret !== 32'd1) begin
            errors++;
            $display("FAIL r_instret: got %0d want 1", instret);
        end
    endtask

    task automatic test_load();
        logic [31:0] i0;
        int          held;
        int          cyc;
        i0        = instret;
        opcode    = 5'b00000;
        mem_ready = 1'b1;
        held      = 0;
        cyc       = 1;
        step();
        step();
        cyc = cyc + 2;
        checks++;
        if (state_o !== 3'd3 || alu_src !== 1'b1 || alu_op !== 2'b00) begin
            errors++;
            $display("FAIL ld_exec: got st=%0d src=%b op=%b want 3/1/00",
                     state_o, alu_src, alu_op);
        end
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            cyc++;
            if (i == 3) begin
                mem_ready = 1'b1;
                #1;
            end
            if (state_o == 3'd4 && mem_read && i_or_d && !mem_write) held++;
        end
        checks++;
        if (held !== 4) begin
            errors++;
            $display("FAIL ld_mem_hold: got %0d cycles want 4", held);
        end
        step();
        cyc++;
        checks++;
        if (state_o !== 3'd5 || mem_to_reg !== 1'b1 || reg_write !== 1'b1) begin
            errors++;
            $display("FAIL ld_wb: got st=%0d m2r=%b rw=%b want 5/1/1",
                     state_o, mem_to_reg, reg_write);
        end
        step();
        checks++;
        if (cyc !== 8 || state_o !== 3'd1 || instret !== i0 + 32'd1) begin
            errors++;
            $display("FAIL ld_done: got cyc=%0d st=%0d instret=%0d want 8/1/%0d",
                     cyc, state_o, instret, i0 + 32'd1);
        end
    endtask

    task automatic test_store();
        logic [31:0] i0;
        int          wr;
        int          rw;
        i0        = instret;
        opcode    = 5'b01000;
        mem_ready = 1'b1;
        wr        = 0;
        rw        = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            wr += int'(mem_write);
            rw += int'(reg_write);
        end
        checks++;
        if (state_o !== 3'd4 || i_or_d !== 1'b1 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL st_mem: got st=%0d iord=%b rd=%b want 4/1/0",
                     state_o, i_or_d, mem_read);
        end
        step();
        checks++;
        if (wr !== 1 || rw !== 0 || state_o !== 3'd1 || instret !== i0 + 32'd1) begin
            errors++;
            $display("FAIL st_done: got wr=%0d rw=%0d st=%0d instret=%0d want 1/0/1/%0d",
                     wr, rw, state_o, instret, i0 + 32'd1);
        end
    endtask

    task automatic test_branch(input logic z);
        logic [31:0] i0;
        i0        = instret;
        opcode    = 5'b11000;
        mem_ready = 1'b1;
        zero      = z;
        step();
        step();
        checks++;
        if (state_o !== 3'd3 || alu_op !== 2'b01 || pc_write_br !== z) begin
            errors++;
            $display("FAIL br_exec_z%0d: got st=%0d op=%b pcbr=%b want 3/01/%b",
                     z, state_o, alu_op, pc_write_br, z);
        end
        step();
        checks++;
        if (state_o !== 3'd1 || instret !== i0 + 32'd1 || pc_write_br !== 1'b0) begin
            errors++;
            $display("FAIL br_done_z%0d: got st=%0d instret=%0d want 1/%0d",
                     z, state_o, instret, i0 + 32'd1);
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal();
        logic [31:0] i0;
        i0        = instret;
        opcode    = 5'b11111;
        mem_ready = 1'b1;
        step();
        checks++;
        if (state_o !== 3'd2 || illegal_op !== 1'b1) begin
            errors++;
            $display("FAIL ill_decode: got st=%0d ill=%b want 2/1", state_o, illegal_op);
        end
        step();
        checks++;
        if (state_o !== 3'd1 || illegal_op !== 1'b0 || instret !== i0) begin
            errors++;
            $display("FAIL ill_after: got st=%0d ill=%b instret=%0d want 1/0/%0d",
                     state_o, illegal_op, instret, i0);
        end
    endtask

    task automatic test_stall();
        logic [31:0] i0;
        int          errs;
        i0        = instret;
        opcode    = 5'b01000;
        mem_ready = 1'b1;
        errs      = 0;
        step();
        step();
        mem_ready = 1'b0;
`ifdef MEM_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k < 16 && (bus_err || state_o != 3'd4)) errs++;
        end
        checks++;
        if (errs !== 0 || bus_err !== 1'b1 || mem_write !== 1'b1) begin
            errors++;
            $display("FAIL tmo_pulse: got early=%0d berr=%b wr=%b want 0/1/1",
                     errs, bus_err, mem_write);
        end
        step();
        checks++;
        if (state_o !== 3'd0 || bus_err !== 1'b0 || instret !== i0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL tmo_after: got st=%0d berr=%b instret=%0d want 0/0/%0d",
                     state_o, bus_err, instret, i0);
        end
        mem_ready = 1'b1;
        step();
`else
        for (int k = 1; k <= 20; k++) begin
            step();
            if (bus_err || state_o != 3'd4 || !mem_write) errs++;
        end
        checks++;
        if (errs !== 0) begin
            errors++;
            $display("FAIL long_stall: got %0d bad cycles want 0", errs);
        end
        mem_ready = 1'b1;
        step();
        checks++;
        if (state_o !== 3'd1 || instret !== i0 + 32'd1) begin
            errors++;
            $display("FAIL stall_done: got st=%0d instret=%0d want 1/%0d",
                     state_o, instret, i0 + 32'd1);
        end
`endif
        checks++;
        if (state_o !== 3'd1) begin
            errors++;
            $display("FAIL stall_fetch: got st=%0d want 1", state_o);
        end
    endtask

    task automatic test_reset_mid();
        opcode    = 5'b00000;
        mem_ready = 1'b1;
        step();
        step();
        mem_ready = 1'b0;
        step();
        step();
        checks++;
        if (state_o !== 3'd4 || mem_read !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: got st=%0d rd=%b want 4/1", state_o, mem_read);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 15'd0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid: got outs=%h instret=%0d want 0/0",
                     all_outs(), instret);
        end
        mem_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (state_o !== 3'd1 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_resume: got st=%0d rw=%b want 1/0", state_o, reg_write);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (excl_viol !== 0) begin
            errors++;
            $display("FAIL exclusivity: got %0d violations want 0", excl_viol);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        excl_viol = 0;
        test_reset();
        test_rtype();
        test_load();
        test_store();
        test_branch(1'b1);
        test_branch(1'b0);
        test_illegal();
        test_stall();
        test_reset_mid();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
